// File: rtl/uart_arb_pkg.sv
// ============================================================================
// Module   : uart_arb_pkg
// Brief    : Shared types and constants for the UART transmit arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_arb_pkg;

    localparam int c_byte_w = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin requester select with lock override.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    input  logic               lock_hold,
    input  logic [2:0]         gnt_id,
    output logic               sel_valid,
    output logic [2:0]         sel_idx
);

    logic w_lock_req;

    always_comb begin
        w_lock_req = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt_id == 3'(j) && req[j]) begin
                w_lock_req = 1'b1;
            end
        end
    end

    // Scan distances from rr_ptr far-to-near so the nearest requester wins last.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 3'd0;
        if (lock_hold && w_lock_req) begin
            sel_valid = 1'b1;
            sel_idx   = gnt_id;
        end else begin
            for (int d = NUM_REQ - 1; d >= 0; d--) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (req[j] && (((j >= int'(rr_ptr)) ? (j - int'(rr_ptr))
                                                        : (j + NUM_REQ - int'(rr_ptr))) == d)) begin
                        sel_valid = 1'b1;
                        sel_idx   = 3'(j);
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arb.sv
// ============================================================================
// Module   : uart_tx_arb
// Brief    : Round-robin arbiter sharing one UART transmitter between requesters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int GAP_CYCLES = 0,
    parameter int TMO_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [c_byte_w*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          trmt,
    output logic [c_byte_w-1:0]           tx_data,
    input  logic                          tx_done,
    output logic                          busy,
    output logic [2:0]                    gnt_id,
    output logic                          tmo_err
);

    localparam int c_ptr_w = $clog2(NUM_REQ);
    localparam int c_tmo_w = $clog2(TMO_CYCLES) + 1;
    localparam int c_gap_w = $clog2(GAP_CYCLES) + 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TMO_CYCLES - 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t               r_state,     w_state_nxt;
    logic [NUM_REQ-1:0]   r_ack,       w_ack_nxt;
    logic                 r_trmt,      w_trmt_nxt;
    logic [c_byte_w-1:0]  r_tx_data,   w_tx_data_nxt;
    logic                 r_busy,      w_busy_nxt;
    logic [2:0]           r_gnt_id,    w_gnt_id_nxt;
    logic                 r_tmo_err,   w_tmo_err_nxt;
    logic [c_ptr_w-1:0]   r_rr_ptr,    w_rr_ptr_nxt;
    logic                 r_lock_hold, w_lock_hold_nxt;
    logic [c_tmo_w-1:0]   r_tmo_cnt,   w_tmo_cnt_nxt;
    logic [c_gap_w-1:0]   r_gap_cnt,   w_gap_cnt_nxt;

    logic                 w_sel_valid;
    logic [2:0]           w_sel_idx;
    logic [c_byte_w-1:0]  w_sel_data;
    logic                 w_gnt_lock;
    logic [c_ptr_w-1:0]   w_ptr_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptr_w)
    ) u_rr_pick (
        .req       (req),
        .rr_ptr    (r_rr_ptr),
        .lock_hold (r_lock_hold),
        .gnt_id    (r_gnt_id),
        .sel_valid (w_sel_valid),
        .sel_idx   (w_sel_idx)
    );

    always_comb begin
        w_sel_data = '0;
        w_gnt_lock = 1'b0;
        w_ptr_inc  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_sel_idx == 3'(j)) begin
                w_sel_data = req_data[j*c_byte_w +: c_byte_w];
            end
            if (r_gnt_id == 3'(j)) begin
                w_gnt_lock = req_lock[j];
                w_ptr_inc  = c_ptr_w'((j + 1) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ack_nxt       = '0;
        w_trmt_nxt      = 1'b0;
        w_tx_data_nxt   = r_tx_data;
        w_gnt_id_nxt    = r_gnt_id;
        w_tmo_err_nxt   = 1'b0;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_lock_hold_nxt = r_lock_hold;
        w_tmo_cnt_nxt   = r_tmo_cnt;
        w_gap_cnt_nxt   = r_gap_cnt;
        case (r_state)
            IDLE: begin
                if (w_sel_valid) begin
                    w_state_nxt   = LOAD;
                    w_tx_data_nxt = w_sel_data;
                    w_gnt_id_nxt  = w_sel_idx;
                    w_trmt_nxt    = 1'b1;
                    for (int j = 0; j < NUM_REQ; j++) begin
                        w_ack_nxt[j] = (w_sel_idx == 3'(j));
                    end
                end else begin
                    w_lock_hold_nxt = 1'b0;
                end
            end
            LOAD: begin
                w_state_nxt   = WAIT;
                w_tmo_cnt_nxt = '0;
            end
            WAIT: begin
                // A zero count marks the first WAIT cycle, where a stale tx_done is dropped.
                if (tx_done && (r_tmo_cnt != '0)) begin
                    w_lock_hold_nxt = w_gnt_lock;
                    if (!w_gnt_lock) begin
                        w_rr_ptr_nxt = w_ptr_inc;
                    end
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else if (r_tmo_cnt == c_tmo_last) begin
                    w_tmo_err_nxt   = 1'b1;
                    w_lock_hold_nxt = 1'b0;
                    w_rr_ptr_nxt    = w_ptr_inc;
                    w_state_nxt     = IDLE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                end
            end
            GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ack       <= '0;
            r_trmt      <= 1'b0;
            r_tx_data   <= '0;
            r_busy      <= 1'b0;
            r_gnt_id    <= 3'd0;
            r_tmo_err   <= 1'b0;
            r_rr_ptr    <= '0;
            r_lock_hold <= 1'b0;
            r_tmo_cnt   <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ack       <= w_ack_nxt;
            r_trmt      <= w_trmt_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_busy      <= w_busy_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_tmo_err   <= w_tmo_err_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_lock_hold <= w_lock_hold_nxt;
            r_tmo_cnt   <= w_tmo_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
        end
    end

    assign ack     = r_ack;
    assign trmt    = r_trmt;
    assign tx_data = r_tx_data;
    assign busy    = r_busy;
    assign gnt_id  = r_gnt_id;
    assign tmo_err = r_tmo_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
// ============================================================================
// Module   : tb_uart_tx_arb
// Brief    : Randomized requester/UART agents with a timestamp-based arbiter model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arb;

    localparam int NUM_REQ = 3;
    localparam int GAP     = 5;
    localparam int TMO     = 16;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [2:0]  req      = '0;
    logic [23:0] req_data = '0;
    logic [2:0]  req_lock = '0;
    logic        tx_done  = 1'b0;
    logic [2:0]  ack;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        busy;
    logic [2:0]  gnt_id;
    logic        tmo_err;

    uart_tx_arb #(
        .NUM_REQ    (NUM_REQ),
        .GAP_CYCLES (GAP),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .req_lock (req_lock),
        .ack      (ack),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy),
        .gnt_id   (gnt_id),
        .tmo_err  (tmo_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q [NUM_REQ][$];
    bit mon_en   = 1'b0;
    bit resp_en  = 1'b0;
    int tmo_left = 0;
    int tmo_pct  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration rule: locked owner first, else first pending from ptr.
    function automatic int pick(input logic [2:0] r, input int ptr, input bit lk, input int gnt);
        if (lk && r[gnt]) return gnt;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Requester agent: presents bytes, records them in the scoreboard, holds req until ack.
    task automatic agent(input int i, input int nbytes, input int lock_pct,
                         input bit rnd, input logic [7:0] base, input int hold_pct);
        logic [7:0] d;
        int w;
        for (int b = 0; b < nbytes; b++) begin
            d = rnd ? 8'($urandom) : base;
            req_data[8*i +: 8] = d;
            exp_q[i].push_back(d);
            req_lock[i] = ($urandom_range(99) < lock_pct);
            req[i] = 1'b1;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!ack[i] && w < 3000);
            checks++;
            if (!ack[i]) begin
                failures++;
                $display("FAIL ack_wait req%0d: got no ack expected ack within 3000 clks", i);
                req[i] = 1'b0;
                req_lock[i] = 1'b0;
                return;
            end
            if (b == nbytes - 1 || $urandom_range(99) >= hold_pct) begin
                req[i] = 1'b0;
                repeat ($urandom_range(6)) @(negedge clk);
            end
        end
        req_lock[i] = 1'b0;
    endtask

    // UART model: answers each trmt with tx_done after a random delay, or never.
    initial begin : responder
        int target;
        int pos;
        forever begin
            @(negedge clk);
            if (resp_en && trmt) begin
                if (tmo_left > 0) begin
                    tmo_left--;
                end else if ($urandom_range(99) >= tmo_pct) begin
                    target = ($urandom_range(3) == 0) ? TMO + 1 : $urandom_range(TMO + 1, 3);
                    pos = 1;
                    if (target >= 4 && $urandom_range(1) == 1) begin
                        @(negedge clk);
                        pos = 2;
                        tx_done = 1'b1;
                        @(negedge clk);
                        pos = 3;
                        tx_done = 1'b0;
                    end
                    while (pos < target) begin
                        @(negedge clk);
                        pos++;
                    end
                    tx_done = 1'b1;
                    @(negedge clk);
                    tx_done = 1'b0;
                end
            end
        end
    end

    // Monitor: edge-indexed timeline model; n is the edge count since reset release.
    initial begin : monitor
        int n = 0, m_t = 0, m_ready = 0, m_ptr = 0, m_gnt = 0, p;
        bit m_lock = 1'b0, m_active = 1'b0;
        logic [7:0] m_data = '0;
        logic [2:0] e_ack;
        bit e_trmt, e_tmo, e_busy;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                n++;
                e_ack = '0;
                e_trmt = 1'b0;
                e_tmo = 1'b0;
                if (!m_active && (n - 1 >= m_ready)) begin
                    p = pick(req, m_ptr, m_lock, m_gnt);
                    if (p < 0) begin
                        m_lock = 1'b0;
                    end else begin
                        e_trmt = 1'b1;
                        e_ack[p] = 1'b1;
                        m_gnt = p;
                        m_active = 1'b1;
                        m_t = n;
                        chk("sb_has_byte", int'(exp_q[p].size() > 0), 1);
                        if (exp_q[p].size() > 0) m_data = exp_q[p].pop_front();
                    end
                end else if (m_active && n >= m_t + 3 && tx_done) begin
                    m_lock = req_lock[m_gnt];
                    if (!m_lock) m_ptr = (m_gnt + 1) % NUM_REQ;
                    m_active = 1'b0;
                    m_ready = n + GAP;
                end else if (m_active && n == m_t + 1 + TMO) begin
                    e_tmo = 1'b1;
                    m_lock = 1'b0;
                    m_ptr = (m_gnt + 1) % NUM_REQ;
                    m_active = 1'b0;
                    m_ready = n;
                end
                e_busy = m_active || (n < m_ready);
                chk("trmt",    trmt,    e_trmt);
                chk("ack",     ack,     e_ack);
                chk("busy",    busy,    e_busy);
                chk("tmo_err", tmo_err, e_tmo);
                chk("gnt_id",  gnt_id,  m_gnt);
                chk("tx_data", tx_data, m_data);
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w;
        bit bad;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",     ack,     0);
        chk("rst_trmt",    trmt,    0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy",    busy,    0);
        chk("rst_gnt_id",  gnt_id,  0);
        chk("rst_tmo_err", tmo_err, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        resp_en = 1'b1;

        // Fairness: all three pending from reset.
        fork
            agent(0, 4, 0, 1'b0, 8'hA0, 100);
            agent(1, 4, 0, 1'b0, 8'hA1, 100);
            agent(2, 4, 0, 1'b0, 8'hA2, 100);
        join
        repeat (30) @(negedge clk);

        agent(1, 1, 0, 1'b0, 8'h67, 0);
        repeat (30) @(negedge clk);

        // Lock: requester 2 keeps the grant while requester 0 waits.
        fork
            agent(2, 4, 100, 1'b0, 8'hC2, 100);
            begin
                repeat (2) @(negedge clk);
                agent(0, 2, 0, 1'b0, 8'hC0, 100);
            end
        join
        repeat (30) @(negedge clk);

        // Timeout on the first byte, then the other requester proceeds.
        tmo_left = 1;
        fork
            agent(0, 1, 0, 1'b0, 8'h3C, 0);
            agent(1, 1, 0, 1'b0, 8'h4D, 0);
        join
        repeat (40) @(negedge clk);

        tmo_pct = 10;
        fork
            agent(0, 15, 30, 1'b1, 8'h00, 50);
            agent(1, 15, 30, 1'b1, 8'h00, 50);
            agent(2, 15, 30, 1'b1, 8'h00, 50);
        join
        repeat (40) @(negedge clk);
        tmo_pct = 0;
        for (int i = 0; i < NUM_REQ; i++) chk("sb_drain", exp_q[i].size(), 0);

        // Reset in the middle of WAIT.
        mon_en = 1'b0;
        resp_en = 1'b0;
        req_data[15:8] = 8'h5A;
        req[1] = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!ack[1] && w < 100);
        chk("rst_test_ack", ack[1], 1);
        req[1] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ack",     ack,     0);
        chk("async_rst_trmt",    trmt,    0);
        chk("async_rst_tx_data", tx_data, 0);
        chk("async_rst_busy",    busy,    0);
        chk("async_rst_gnt_id",  gnt_id,  0);
        chk("async_rst_tmo_err", tmo_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ack != 3'b000 || trmt || busy) bad = 1'b1;
        end
        chk("post_rst_quiet", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
